nrisc_fetch: RTL and testbench
==============================

Name: nrisc_fetch

Overview:
Instruction fetch stage of the 8-bit nRisc core. It sits directly upstream of the instruction splitter/decoder. It owns the program counter and drives the instruction-memory address. It captures the returned word and presents it to the decoder with a valid/ready handshake, honouring branch redirects and halt requests from the execute side.

Parameters:
ADDR_WIDTH, 8, width of PC and instruction-memory address.
RESET_PC, 8'h00, PC value loaded on reset.
MEM_LATENCY, 1, cycles from imem_addr update to imem_rdata valid; legal range 1..3.

Ports:
clock  input  1  single rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
imem_addr  output  ADDR_WIDTH  registered address to instruction memory.
imem_rdata  input  8  instruction word from memory, valid MEM_LATENCY cycles after imem_addr changes.
instruction  output  8  captured instruction word presented to the decoder.
instr_valid  output  1  instruction holds a valid word.
instr_ready  input  1  decoder accepts instruction at this edge.
pc_out  output  ADDR_WIDTH  address of the word currently in instruction.
branch_taken  input  1  one-cycle redirect strobe.
branch_target  input  ADDR_WIDTH  redirect address, sampled when branch_taken=1.
halt_req  input  1  level request to stop fetching.
halted  output  1  fetch unit is parked in HALT.

Behaviour:
- Reset (reset_n=0, asynchronous): pc=RESET_PC, imem_addr=RESET_PC, instruction=8'h00, pc_out=RESET_PC, instr_valid=0, halted=0, lat_cnt=0, state=IDLE. All outputs are registered.
- States: IDLE, REQ, WAIT, HOLD, HALT.
- IDLE: unconditionally goes to REQ on the first edge after reset release.
- REQ:
  - halt_req=1: go to HALT; imem_addr unchanged.
  - Otherwise: imem_addr<=pc, lat_cnt<=MEM_LATENCY, go to WAIT.
- WAIT: lat_cnt decrements each edge. On the edge where lat_cnt==1:
  - instruction<=imem_rdata, pc_out<=pc, instr_valid<=1.
  - pc<=pc+1, wrapping mod 2^ADDR_WIDTH (8'hFF -> 8'h00).
  - Go to HOLD.
- HOLD: instruction, pc_out and instr_valid stay stable until an edge with instr_ready=1. On that edge instr_valid<=0 and the unit goes to REQ.
- Throughput: one instruction per MEM_LATENCY+2 cycles when instr_ready is held high.
- Redirect (branch_taken=1 at an edge; checked before the per-state rules above):
  - pc<=branch_target in every state.
  - In WAIT: the in-flight word is discarded, instruction is not updated, go to REQ.
  - In HOLD with instr_ready=0: instr_valid<=0 (wrong-path word flushed), go to REQ.
  - In HOLD with instr_ready=1: the handshake completes (word consumed), then go to REQ at the target.
  - In REQ: go to REQ, or to HALT if halt_req=1.
  - In HALT: pc is updated and the unit stays halted.
- Halt timing: halt_req is only acted on in REQ, so an in-flight fetch always completes and is handed off first. In HALT, halted=1. When halt_req=0 the unit goes to REQ (halted<=0) and resumes at pc.
- instr_valid never rises in the cycle that branch_taken is sampled.
- Mid-operation reset: asynchronous reset forces the reset values immediately and drops any held instruction. Fetch restarts at RESET_PC.
- No combinational path from any input to any output.

Test Plan:
1. Reset release, MEM_LATENCY=1, ROM[a]=a^8'hA5, instr_ready=1 -> words 8'hA5, 8'hA4, 8'hA7 with pc_out 0,1,2. instr_valid pulses every 3 cycles. imem_addr 0,1,2.
2. Backpressure: instr_ready=0 for 5 cycles after the first valid -> instruction=8'hA5 and instr_valid=1 held stable. imem_addr stays 0. Next word arrives only after ready=1.
3. Redirect in WAIT: branch_taken=1, target=8'h40 while fetching address 3 -> word for 3 never presented. Next valid has pc_out=8'h40, instruction=8'hE5.
4. Redirect in HOLD with ready=0 (target 8'h10) -> instr_valid drops the next cycle. Next valid has pc_out=8'h10, instruction=8'hB5. Repeat with ready=1: the held word is consumed, then the same target sequence follows.
5. halt_req=1 during WAIT -> the current word is delivered, then halted=1 with no imem_addr change. Deassert -> fetch resumes at the next sequential PC.
6. PC wrap with MEM_LATENCY=3: branch to 8'hFF -> valid words at pc_out 8'hFF then 8'h00, each 5 cycles apart. Then assert reset_n=0 mid-WAIT -> instr_valid=0 and imem_addr=8'h00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/nrisc_fetch.sv
// nrisc_fetch: program counter, instruction-memory request and decoder handoff for the nRisc core
module nrisc_fetch #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [7:0]            imem_rdata,
    output logic [7:0]            instruction,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] pc_out,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  halt_req,
    output logic                  halted
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;
    localparam logic [1:0]            LAT = 2'(MEM_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] ONE = 1;
    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [1:0]            lat_cnt;
    // fetch FSM; a redirect always reloads pc, overriding the sequential increment
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_addr   <= RESET_PC;
            pc_out      <= RESET_PC;
            instruction <= 8'h00;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            lat_cnt     <= 2'd0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ:
                    if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (!branch_taken) begin
                        imem_addr <= pc;
                        lat_cnt   <= LAT;
                        state     <= WAIT;
                    end
                WAIT:
                    if (branch_taken) state <= REQ;
                    else if (lat_cnt == 2'd1) begin
                        instruction <= imem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + ONE;
                        state       <= HOLD;
                    end else lat_cnt <= lat_cnt - 2'd1;
                HOLD:
                    if (instr_ready || branch_taken) begin
                        instr_valid <= 1'b0;
                        state       <= REQ;
                    end
                HALT:
                    if (!halt_req) begin
                        halted <= 1'b0;
                        state  <= REQ;
                    end
                default: state <= IDLE;
            endcase
            if (branch_taken) pc <= branch_target;
        end
    end
endmodule

// File: tb/tb_nrisc_fetch.sv
// tb_nrisc_fetch: directed checks of nrisc_fetch at memory latency 1 and 3
module tb_nrisc_fetch;
    logic       clk = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       rst_n1, ready1, br1, halt1;
    logic [7:0] tgt1, addr1, rdata1, instr1, pco1;
    logic       valid1, halted1;
    logic       rst_n3, ready3, br3, halt3;
    logic [7:0] tgt3, addr3, rdata3, instr3, pco3;
    logic       valid3, halted3;

    always #5 clk = ~clk;

    assign rdata1 = addr1 ^ 8'hA5;
    assign rdata3 = addr3 ^ 8'hA5;

    nrisc_fetch #(.ADDR_WIDTH(8), .RESET_PC(8'h00), .MEM_LATENCY(1)) u_l1 (
        .clock(clk), .reset_n(rst_n1), .imem_addr(addr1), .imem_rdata(rdata1),
        .instruction(instr1), .instr_valid(valid1), .instr_ready(ready1), .pc_out(pco1),
        .branch_taken(br1), .branch_target(tgt1), .halt_req(halt1), .halted(halted1)
    );

    nrisc_fetch #(.ADDR_WIDTH(8), .RESET_PC(8'h00), .MEM_LATENCY(3)) u_l3 (
        .clock(clk), .reset_n(rst_n3), .imem_addr(addr3), .imem_rdata(rdata3),
        .instruction(instr3), .instr_valid(valid3), .instr_ready(ready3), .pc_out(pco3),
        .branch_taken(br3), .branch_target(tgt3), .halt_req(halt3), .halted(halted3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset1();
        rst_n1 = 1'b0;
        tick();
        tick();
        rst_n1 = 1'b1;
    endtask

    initial begin
        rst_n1 = 1'b0; ready1 = 1'b1; br1 = 1'b0; tgt1 = 8'h00; halt1 = 1'b0;
        rst_n3 = 1'b0; ready3 = 1'b1; br3 = 1'b0; tgt3 = 8'h00; halt3 = 1'b0;
        tick();
        tick();
        check("rst_addr", addr1, 8'h00);
        check("rst_valid", valid1, 0);
        check("rst_instr", instr1, 8'h00);
        check("rst_pc_out", pco1, 8'h00);
        check("rst_halted", halted1, 0);
        rst_n1 = 1'b1;
        // sequential fetch, ready held high
        tick();
        check("t1_e1_valid", valid1, 0);
        tick();
        check("t1_addr0", addr1, 8'h00);
        check("t1_e2_valid", valid1, 0);
        tick();
        check("t1_w0_valid", valid1, 1);
        check("t1_w0_instr", instr1, 8'hA5);
        check("t1_w0_pc", pco1, 8'h00);
        tick();
        check("t1_e4_valid", valid1, 0);
        tick();
        check("t1_addr1", addr1, 8'h01);
        tick();
        check("t1_w1_valid", valid1, 1);
        check("t1_w1_instr", instr1, 8'hA4);
        check("t1_w1_pc", pco1, 8'h01);
        tick();
        check("t1_e7_valid", valid1, 0);
        tick();
        check("t1_e8_valid", valid1, 0);
        check("t1_addr2", addr1, 8'h02);
        tick();
        check("t1_w2_valid", valid1, 1);
        check("t1_w2_instr", instr1, 8'hA7);
        check("t1_w2_pc", pco1, 8'h02);
        // backpressure on the first word after a fresh reset
        ready1 = 1'b0;
        reset1();
        tick();
        tick();
        tick();
        check("t2_first_valid", valid1, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", valid1, 1);
            check("t2_hold_instr", instr1, 8'hA5);
            check("t2_hold_addr", addr1, 8'h00);
        end
        ready1 = 1'b1;
        tick();
        check("t2_release_valid", valid1, 0);
        tick();
        check("t2_addr1", addr1, 8'h01);
        tick();
        check("t2_w1_instr", instr1, 8'hA4);
        check("t2_w1_pc", pco1, 8'h01);
        // redirect while fetching address 3
        tick();
        tick();
        tick();
        check("t3_w2_pc", pco1, 8'h02);
        tick();
        tick();
        check("t3_addr3", addr1, 8'h03);
        br1 = 1'b1; tgt1 = 8'h40;
        tick();
        br1 = 1'b0;
        check("t3_flush_valid", valid1, 0);
        tick();
        check("t3_addr40", addr1, 8'h40);
        check("t3_no_word3", valid1, 0);
        tick();
        check("t3_tgt_valid", valid1, 1);
        check("t3_tgt_pc", pco1, 8'h40);
        check("t3_tgt_instr", instr1, 8'hE5);
        // redirect in HOLD with ready low flushes the held word
        ready1 = 1'b0; br1 = 1'b1; tgt1 = 8'h10;
        tick();
        br1 = 1'b0; ready1 = 1'b1;
        check("t4a_flush_valid", valid1, 0);
        tick();
        check("t4a_addr10", addr1, 8'h10);
        tick();
        check("t4a_tgt_pc", pco1, 8'h10);
        check("t4a_tgt_instr", instr1, 8'hB5);
        // redirect in HOLD with ready high consumes the word first
        br1 = 1'b1;
        tick();
        br1 = 1'b0;
        check("t4b_consumed_valid", valid1, 0);
        tick();
        check("t4b_addr10", addr1, 8'h10);
        tick();
        check("t4b_tgt_valid", valid1, 1);
        check("t4b_tgt_pc", pco1, 8'h10);
        // halt raised during WAIT: word 11 still delivered
        tick();
        tick();
        check("t5_addr11", addr1, 8'h11);
        halt1 = 1'b1;
        tick();
        check("t5_w11_valid", valid1, 1);
        check("t5_w11_instr", instr1, 8'hB4);
        check("t5_w11_halted", halted1, 0);
        tick();
        check("t5_req_halted", halted1, 0);
        tick();
        check("t5_halted", halted1, 1);
        check("t5_halt_addr", addr1, 8'h11);
        tick();
        tick();
        check("t5_still_halted", halted1, 1);
        check("t5_still_addr", addr1, 8'h11);
        halt1 = 1'b0;
        tick();
        check("t5_resume_halted", halted1, 0);
        tick();
        check("t5_addr12", addr1, 8'h12);
        tick();
        check("t5_w12_pc", pco1, 8'h12);
        check("t5_w12_instr", instr1, 8'hB7);
        // latency 3: wrap from FF to 00, then async reset mid-WAIT
        rst_n3 = 1'b1; br3 = 1'b1; tgt3 = 8'hFF;
        tick();
        br3 = 1'b0;
        tick();
        check("t6_addrFF", addr3, 8'hFF);
        tick();
        tick();
        check("t6_e4_valid", valid3, 0);
        tick();
        check("t6_wFF_valid", valid3, 1);
        check("t6_wFF_pc", pco3, 8'hFF);
        check("t6_wFF_instr", instr3, 8'h5A);
        tick();
        tick();
        check("t6_addr00", addr3, 8'h00);
        tick();
        tick();
        check("t6_e9_valid", valid3, 0);
        tick();
        check("t6_w00_valid", valid3, 1);
        check("t6_w00_pc", pco3, 8'h00);
        check("t6_w00_instr", instr3, 8'hA5);
        tick();
        tick();
        check("t6_addr01", addr3, 8'h01);
        #2;
        rst_n3 = 1'b0;
        #1;
        check("t6_async_addr", addr3, 8'h00);
        check("t6_async_valid", valid3, 0);
        check("t6_async_instr", instr3, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
